// File: rtl/audio_fx_pkg.sv
// Shared definitions for the audio effects path: mode encodings, default
// sample width and the saturating clamp used by the echo and volume stages.
package audio_fx_pkg;

  localparam int DW_DEFAULT = 16;

  typedef enum logic [1:0] {
    MODE_BYPASS  = 2'b00,
    MODE_ECHO    = 2'b01,
    MODE_LP      = 2'b10,
    MODE_LP_ECHO = 2'b11
  } fx_mode_e;

  // Clamp a wide signed value to the two's complement range of a dw-bit sample.
  function automatic logic signed [63:0] sat(input logic signed [63:0] v, input int dw);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (dw - 1));
    if (v > hi) return hi;
    else if (v < lo) return lo;
    else return v;
  endfunction

endpackage

// File: rtl/audio_fx_delay_ram.sv
// Echo delay line storage: one write port and one synchronous read port on a
// shared address, returning the old contents when read and write coincide.
module audio_fx_delay_ram #(
  parameter int DW    = 16,
  parameter int DEPTH = 4096,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          i_en,
  input  logic [AW-1:0] i_addr,
  input  logic [DW-1:0] i_wdata,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_en) begin
      o_rdata        <= r_mem[i_addr];
      r_mem[i_addr]  <= i_wdata;
    end
  end

endmodule

// File: rtl/audio_fx_chain.sv
// Three-stage effects path: moving-average lowpass, feed-forward echo and
// stepped volume with saturation. One sample per cycle, fixed 3-cycle latency.
module audio_fx_chain
  import audio_fx_pkg::*;
#(
  parameter int DW           = DW_DEFAULT,
  parameter int ECHO_DEPTH   = 4096,
  parameter int ECHO_SHIFT   = 1,
  parameter int LP_TAPS_LOG2 = 2,
  parameter int VOL_BITS     = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                s_valid,
  input  logic [DW-1:0]       s_data,
  input  logic [1:0]          mode,
  input  logic                vol_up,
  input  logic                vol_dn,
  output logic                m_valid,
  output logic [DW-1:0]       m_data,
  output logic [VOL_BITS-1:0] vol_level,
  output logic                clip
);

  localparam int NTAPS = 1 << LP_TAPS_LOG2;
  localparam int SW    = DW + LP_TAPS_LOG2;
  localparam int AW    = $clog2(ECHO_DEPTH);
  localparam int PW    = DW + VOL_BITS + 1;
  localparam logic [VOL_BITS-1:0] VOL_UNITY = {1'b1, {(VOL_BITS-1){1'b0}}};
  localparam logic [VOL_BITS-1:0] VOL_MAX   = '1;

  // Stage 1: lowpass history, mode decode, delay-line addressing
  logic signed [DW-1:0] r_hist [NTAPS];
  logic signed [SW-1:0] r_sum;
  logic [AW-1:0]        r_wr_ptr;
  logic                 r_fill;
  logic                 r_s1_valid;
  logic signed [DW-1:0] r_s1_y;
  logic                 r_s1_echo;
  logic                 r_s1_fill;

  logic signed [DW-1:0] w_x;
  logic signed [SW-1:0] w_sum_nxt;
  logic signed [SW-1:0] w_lp_shift;
  logic signed [DW-1:0] w_y1;
  logic                 w_lp_en;
  logic                 w_echo_en;
  logic [DW-1:0]        w_ram_rd;

  assign w_x        = signed'(s_data);
  assign w_sum_nxt  = r_sum + SW'(w_x) - SW'(r_hist[NTAPS-1]);
  assign w_lp_shift = w_sum_nxt >>> LP_TAPS_LOG2;
  assign w_lp_en    = (mode == MODE_LP) || (mode == MODE_LP_ECHO);
  assign w_echo_en  = (mode == MODE_ECHO) || (mode == MODE_LP_ECHO);
  assign w_y1       = w_lp_en ? w_lp_shift[DW-1:0] : w_x;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NTAPS; i++) r_hist[i] <= '0;
      r_sum      <= '0;
      r_wr_ptr   <= '0;
      r_fill     <= 1'b0;
      r_s1_valid <= 1'b0;
      r_s1_y     <= '0;
      r_s1_echo  <= 1'b0;
      r_s1_fill  <= 1'b0;
    end else begin
      r_s1_valid <= s_valid;
      if (s_valid) begin
        r_sum     <= w_sum_nxt;
        r_hist[0] <= w_x;
        for (int i = 1; i < NTAPS; i++) r_hist[i] <= r_hist[i-1];
        r_wr_ptr  <= r_wr_ptr + AW'(1);
        if (r_wr_ptr == AW'(ECHO_DEPTH - 1)) r_fill <= 1'b1;
        r_s1_y    <= w_y1;
        r_s1_echo <= w_echo_en;
        // fill as seen by this sample's read decides whether its tap is valid
        r_s1_fill <= r_fill;
      end
    end
  end

  audio_fx_delay_ram #(
    .DW    (DW),
    .DEPTH (ECHO_DEPTH)
  ) u_ram (
    .clk     (clk),
    .i_en    (s_valid),
    .i_addr  (r_wr_ptr),
    .i_wdata (w_y1),
    .o_rdata (w_ram_rd)
  );

  // Stage 2: echo mix
  logic signed [DW-1:0] w_d;
  logic signed [DW:0]   w_echo_sum;
  logic signed [63:0]   w_y2_sat;
  logic                 w_c2;
  logic                 r_s2_valid;
  logic signed [DW-1:0] r_s2_y;
  logic                 r_s2_clip;

  assign w_d        = signed'(w_ram_rd);
  assign w_echo_sum = (DW+1)'(r_s1_y) +
                      ((r_s1_echo && r_s1_fill) ? (DW+1)'(w_d >>> ECHO_SHIFT) : '0);
  assign w_y2_sat   = sat(64'(w_echo_sum), DW);
  assign w_c2       = (w_y2_sat != 64'(w_echo_sum));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s2_valid <= 1'b0;
      r_s2_y     <= '0;
      r_s2_clip  <= 1'b0;
    end else begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_y    <= w_y2_sat[DW-1:0];
        r_s2_clip <= w_c2;
      end
    end
  end

  // Stage 3: volume scale; level changes take effect on the next edge only
  logic [VOL_BITS-1:0] r_vol;
  logic signed [PW-1:0] w_prod;
  logic signed [PW-1:0] w_scaled;
  logic signed [63:0]   w_y3_sat;
  logic                 w_c3;

  assign w_prod   = PW'(r_s2_y) * PW'(signed'({1'b0, r_vol}));
  assign w_scaled = w_prod >>> (VOL_BITS - 1);
  assign w_y3_sat = sat(64'(w_scaled), DW);
  assign w_c3     = (w_y3_sat != 64'(w_scaled));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vol <= VOL_UNITY;
    end else if (vol_up && !vol_dn && (r_vol != VOL_MAX)) begin
      r_vol <= r_vol + VOL_BITS'(1);
    end else if (vol_dn && !vol_up && (r_vol != '0)) begin
      r_vol <= r_vol - VOL_BITS'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      clip    <= 1'b0;
    end else begin
      m_valid <= r_s2_valid;
      clip    <= r_s2_valid && (r_s2_clip || w_c3);
      if (r_s2_valid) m_data <= w_y3_sat[DW-1:0];
    end
  end

  assign vol_level = r_vol;

endmodule

// File: tb/tb_audio_fx_chain.sv
// Self-checking bench for audio_fx_chain with a short echo line (depth 8).
// Expected samples are queued as they are driven and popped as outputs appear.
module tb_audio_fx_chain;

  localparam int DW = 16;
  localparam int ED = 8;
  localparam int VB = 3;

  logic          clk;
  logic          rst;
  logic          s_valid;
  logic [DW-1:0] s_data;
  logic [1:0]    mode;
  logic          vol_up;
  logic          vol_dn;
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic [VB-1:0] vol_level;
  logic          clip;

  int errors = 0;
  int checks = 0;
  logic [DW:0] exp_q[$];
  logic [DW:0] mon_exp;

  // reference model state for the random stream
  int mh [4];
  int mram [ED];
  int msum;
  int mwp;
  int mvol;
  bit mfill;

  audio_fx_chain #(
    .DW(DW), .ECHO_DEPTH(ED), .ECHO_SHIFT(1), .LP_TAPS_LOG2(2), .VOL_BITS(VB)
  ) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_data(s_data), .mode(mode),
    .vol_up(vol_up), .vol_dn(vol_dn), .m_valid(m_valid), .m_data(m_data),
    .vol_level(vol_level), .clip(clip)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard: every output strobe must match the oldest queued expectation
  always @(negedge clk) begin
    if (m_valid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL out_stale: got data=%h clip=%b with no sample outstanding", m_data, clip);
      end else begin
        mon_exp = exp_q.pop_front();
        if ({clip, m_data} !== mon_exp) begin
          errors++;
          $display("FAIL out_sample: got data=%h clip=%b expected data=%h clip=%b",
                   m_data, clip, mon_exp[DW-1:0], mon_exp[DW]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst = 1'b1; s_valid = 1'b0; vol_up = 1'b0; vol_dn = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic send(input logic [DW-1:0] x, input logic [1:0] m,
                      input logic [DW-1:0] ed, input logic ec);
    s_data = x; mode = m; s_valid = 1'b1;
    exp_q.push_back({ec, ed});
    tick();
    s_valid = 1'b0;
  endtask

  task automatic pulse_vol(input logic up, input logic dn);
    vol_up = up; vol_dn = dn;
    tick();
    vol_up = 1'b0; vol_dn = 1'b0;
  endtask

  task automatic drain();
    repeat (5) tick();
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) mh[i] = 0;
    for (int i = 0; i < ED; i++) mram[i] = 0;
    msum = 0; mwp = 0; mfill = 0; mvol = 4;
  endtask

  task automatic send_model(input logic [DW-1:0] x, input logic [1:0] m);
    int sx, s, y1, echo, y2r, y2, y3r, y3;
    logic c;
    logic [DW-1:0] y3_bits;
    sx   = $signed(x);
    s    = msum + sx - mh[3];
    y1   = m[1] ? (s >>> 2) : sx;
    echo = (m[0] && mfill) ? (mram[mwp] >>> 1) : 0;
    y2r  = y1 + echo;
    y2   = (y2r > 32767) ? 32767 : ((y2r < -32768) ? -32768 : y2r);
    c    = (y2 != y2r);
    y3r  = (y2 * mvol) >>> 2;
    y3   = (y3r > 32767) ? 32767 : ((y3r < -32768) ? -32768 : y3r);
    c    = c | (y3 != y3r);
    y3_bits = y3[DW-1:0];
    mh[3] = mh[2]; mh[2] = mh[1]; mh[1] = mh[0]; mh[0] = sx;
    msum = s;
    mram[mwp] = y1;
    mwp = (mwp + 1) % ED;
    if (mwp == 0) mfill = 1;
    send(x, m, y3_bits, c);
  endtask

  task automatic test_reset();
    reset_dut();
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid: got %b want 0", m_valid); end
    checks++; if (m_data !== 16'h0000) begin errors++; $display("FAIL reset_m_data: got %h want 0000", m_data); end
    checks++; if (clip !== 1'b0) begin errors++; $display("FAIL reset_clip: got %b want 0", clip); end
    checks++; if (vol_level !== 3'd4) begin errors++; $display("FAIL reset_vol: got %0d want 4", vol_level); end
  endtask

  task automatic test_bypass_latency();
    reset_dut();
    send(16'h1234, 2'b00, 16'h1234, 1'b0);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      checks++;
      if (m_valid !== (c == 3)) begin
        errors++;
        $display("FAIL latency_c%0d: got m_valid=%b want %b", c, m_valid, (c == 3));
      end
    end
    repeat (3) @(negedge clk);
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL hold_valid: got %b want 0", m_valid); end
    checks++; if (m_data !== 16'h1234) begin errors++; $display("FAIL hold_data: got %h want 1234", m_data); end
    checks++; if (vol_level !== 3'd4) begin errors++; $display("FAIL bypass_vol: got %0d want 4", vol_level); end
  endtask

  task automatic test_lowpass();
    logic [DW-1:0] steps [5];
    steps = '{16'h0400, 16'h0800, 16'h0C00, 16'h1000, 16'h1000};
    reset_dut();
    for (int i = 0; i < 5; i++) send(16'h1000, 2'b10, steps[i], 1'b0);
    drain();
  endtask

  task automatic test_echo();
    reset_dut();
    // leave stale full-scale data in the delay line, then reset it away
    for (int i = 0; i < ED; i++) send(16'h7FFF, 2'b00, 16'h7FFF, 1'b0);
    drain();
    reset_dut();
    send(16'h4000, 2'b01, 16'h4000, 1'b0);
    for (int i = 1; i < ED; i++) send(16'h0000, 2'b01, 16'h0000, 1'b0);
    send(16'h0000, 2'b01, 16'h2000, 1'b0);
    send(16'h0000, 2'b01, 16'h0000, 1'b0);
    drain();
  endtask

  task automatic test_volume_clip();
    logic [VB-1:0] lv [5];
    lv = '{3'd5, 3'd6, 3'd7, 3'd7, 3'd7};
    reset_dut();
    for (int i = 0; i < 5; i++) begin
      pulse_vol(1'b1, 1'b0);
      checks++;
      if (vol_level !== lv[i]) begin
        errors++;
        $display("FAIL vol_up_%0d: got %0d want %0d", i, vol_level, lv[i]);
      end
    end
    send(16'h6000, 2'b00, 16'h7FFF, 1'b1);
    send(16'hA000, 2'b00, 16'h8000, 1'b1);
    drain();
  endtask

  task automatic test_volume_down();
    logic [VB-1:0] lv [5];
    lv = '{3'd3, 3'd2, 3'd1, 3'd0, 3'd0};
    reset_dut();
    pulse_vol(1'b1, 1'b1);
    checks++; if (vol_level !== 3'd4) begin errors++; $display("FAIL vol_both: got %0d want 4", vol_level); end
    for (int i = 0; i < 5; i++) begin
      pulse_vol(1'b0, 1'b1);
      checks++;
      if (vol_level !== lv[i]) begin
        errors++;
        $display("FAIL vol_dn_%0d: got %0d want %0d", i, vol_level, lv[i]);
      end
    end
    send(16'h1234, 2'b00, 16'h0000, 1'b0);
    drain();
  endtask

  task automatic test_back_to_back();
    reset_dut();
    model_reset();
    pulse_vol(1'b1, 1'b0);
    pulse_vol(1'b1, 1'b0);
    mvol = 6;
    for (int i = 0; i < 40; i++)
      send_model(16'($urandom_range(0, 65535)), 2'($urandom_range(0, 3)));
    // stream again and cut it with reset while two samples are in flight
    for (int i = 0; i < 6; i++)
      send_model(16'($urandom_range(0, 65535)), 2'($urandom_range(0, 3)));
    void'(exp_q.pop_back());
    void'(exp_q.pop_back());
    rst = 1'b1;
    tick();
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL rst_flush_valid: got %b want 0", m_valid); end
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++;
      if (m_valid !== 1'b0) begin errors++; $display("FAIL rst_quiet_%0d: got m_valid=%b want 0", c, m_valid); end
    end
    checks++; if (vol_level !== 3'd4) begin errors++; $display("FAIL rst_vol: got %0d want 4", vol_level); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL rst_queue: got %0d pending want 0", exp_q.size()); end
  endtask

  initial begin
    rst = 1'b1; s_valid = 1'b0; s_data = '0; mode = 2'b00; vol_up = 1'b0; vol_dn = 1'b0;
    test_reset();
    test_bypass_latency();
    test_lowpass();
    test_echo();
    test_volume_clip();
    test_volume_down();
    test_back_to_back();
    drain();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL final_queue: got %0d outstanding samples want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
